imem_loader: RTL and testbench

- Writable instruction memory with a byte-stream boot loader.
- Receives a length-prefixed program over a valid/ready byte interface, assembles little-endian 32-bit words and writes them into a word array.
- Once loading completes, it serves combinational CPU instruction fetches indexed by address[9:2].
- Holds the core in reset while loading; replaces a fixed-content instruction memory at the fetch stage.

---
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Writable instruction memory with a length-prefixed byte-stream
//            boot loader and a combinational CPU fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    input  logic [31:0]          address,
    output logic [31:0]          data,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_err,
    output logic [ADDR_BITS:0]   word_count
);

    localparam logic [15:0] C_DEPTH = 16'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [7:0]             r_len_lo;
    logic [ADDR_BITS:0]     r_word_count;
    logic [ADDR_BITS-1:0]   r_ptr;
    logic [1:0]             r_byte_cnt;
    logic [23:0]            r_asm;
    logic [31:0]            r_mem [DEPTH_WORDS];

    logic                   w_accept;
    logic [15:0]            w_len;
    logic                   w_len_bad;
    logic                   w_word_we;
    logic                   w_last_word;
    logic [ADDR_BITS-1:0]   w_idx;
    logic                   w_unused_addr;

    assign rx_ready   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
    assign load_done  = (r_state == S_DONE);
    assign load_err   = (r_state == S_ERROR);
    assign cpu_hold   = (r_state != S_DONE);
    assign word_count = r_word_count;

    assign w_accept    = rx_valid && rx_ready;
    assign w_len       = {rx_data, r_len_lo};
    assign w_len_bad   = (w_len == 16'd0) || (w_len > C_DEPTH);
    assign w_word_we   = w_accept && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
    assign w_last_word = ({1'b0, r_ptr} == (r_word_count - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LEN_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LEN_LO: if (w_accept) w_next_state = S_LEN_HI;
            S_LEN_HI: if (w_accept) w_next_state = w_len_bad ? S_ERROR : S_DATA;
            S_DATA:   if (w_word_we && w_last_word) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_DONE;
            S_ERROR:  w_next_state = S_ERROR;
            default:  w_next_state = S_LEN_LO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_lo     <= 8'd0;
            r_word_count <= '0;
            r_ptr        <= '0;
            r_byte_cnt   <= 2'd0;
            r_asm        <= 24'd0;
        end else if (w_accept) begin
            case (r_state)
                S_LEN_LO: r_len_lo <= rx_data;
                S_LEN_HI: if (!w_len_bad) r_word_count <= w_len[ADDR_BITS:0];
                S_DATA: begin
                    case (r_byte_cnt)
                        2'd0:    r_asm[7:0]   <= rx_data;
                        2'd1:    r_asm[15:8]  <= rx_data;
                        2'd2:    r_asm[23:16] <= rx_data;
                        default: r_ptr        <= r_ptr + 1'b1;
                    endcase
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Array is deliberately not reset; word_count gates what is visible.
    always_ff @(posedge clk) begin
        if (w_word_we) begin
            r_mem[r_ptr] <= {rx_data, r_asm};
        end
    end

    assign w_idx         = address[ADDR_BITS+1:2];
    assign w_unused_addr = ^{address[31:ADDR_BITS+2], address[1:0]};

    always_comb begin
        data = 32'h0;
        if (!cpu_hold && ({1'b0, w_idx} < r_word_count)) begin
            data = r_mem[w_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for the imem_loader boot loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] address;
    logic [31:0] data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [8:0]  word_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog [18] = '{
        32'h00a00093, 32'h00100113, 32'h00000193, 32'h00208233,
        32'h800004b7, 32'h0014a023, 32'hfff08093, 32'hfe009ae3,
        32'h00310133, 32'h00118193, 32'h00412023, 32'h00012283,
        32'h0042a223, 32'h00500313, 32'h40628333, 32'h00030393,
        32'h0000006f, 32'h00000013
    };

    imem_loader #(.DEPTH_WORDS(256), .ADDR_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .address    (address),
        .data       (data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] full_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'hxx;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic send_header(input logic [15:0] n, input bit gaps);
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
    endtask

    task automatic fetch_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        #1;
        checks++;
        if (data !== exp) begin
            errors++;
            $display("FAIL %s addr=%h data=%h expected=%h", name, a, data, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_status(input string name, input logic rdy, input logic hold,
                                input logic done, input logic err, input logic [8:0] wc);
        checks++;
        if ({rx_ready, cpu_hold, load_done, load_err, word_count} !== {rdy, hold, done, err, wc}) begin
            errors++;
            $display("FAIL %s rdy/hold/done/err/wc=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                     name, rx_ready, cpu_hold, load_done, load_err, word_count,
                     rdy, hold, done, err, wc);
        end
    endtask

    task automatic load_prog18(input string name, input bit gaps);
        send_header(16'd18, gaps);
        for (int i = 0; i < 17; i++) send_word(prog[i], gaps);
        for (int k = 0; k < 3; k++) send_byte(prog[17][8*k +: 8], gaps);
        if (gaps) repeat ($urandom_range(1, 3)) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = prog[17][31:24];
        checks++;
        if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL %s_pre_last done=%b hold=%b expected 0/1", name, load_done, cpu_hold);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check_status({name, "_after_last"}, 1'b0, 1'b0, 1'b1, 1'b0, 9'd18);
    endtask

    task automatic test_reset();
        check_status("reset_held", 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_status("reset_released", 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        fetch_check("reset_data", 32'h0, 32'h0);
    endtask

    task automatic test_load18();
        load_prog18("load18", 1'b0);
        fetch_check("load18_a0", 32'h0, 32'h00a00093);
        fetch_check("load18_a10", 32'h10, 32'h800004b7);
        fetch_check("load18_a44", 32'h44, 32'h00000013);
        fetch_check("load18_a48", 32'h48, 32'h0);
        fetch_check("load18_a0_lowbits", 32'h3, 32'h00a00093);
    endtask

    task automatic test_gaps();
        do_reset();
        load_prog18("gaps", 1'b1);
        for (int i = 0; i < 18; i++) fetch_check("gaps_word", 32'(i * 4), prog[i]);
    endtask

    task automatic test_header_err();
        do_reset();
        send_header(16'd0, 1'b0);
        check_status("hdr_n0", 1'b0, 1'b1, 1'b0, 1'b1, 9'd0);
        do_reset();
        send_header(16'd257, 1'b0);
        check_status("hdr_n257", 1'b0, 1'b1, 1'b0, 1'b1, 9'd0);
        send_byte(8'h55, 1'b0);
        check_status("hdr_err_sticky", 1'b0, 1'b1, 1'b0, 1'b1, 9'd0);
        for (int a = 0; a < 32'h400; a += 32'h44) fetch_check("hdr_err_data", 32'(a), 32'h0);
    endtask

    task automatic test_full256();
        do_reset();
        send_header(16'd256, 1'b0);
        for (int i = 0; i < 256; i++) send_word(full_word(i), 1'b0);
        check_status("full_done", 1'b0, 1'b0, 1'b1, 1'b0, 9'd256);
        fetch_check("full_3fc", 32'h3FC, full_word(255));
        fetch_check("full_400_alias", 32'h400, full_word(0));
        fetch_check("full_high_alias", 32'hFFFF_FC80, full_word(32));
        send_word(32'hCAFE_F00D, 1'b0);
        check_status("full_extra_ignored", 1'b0, 1'b0, 1'b1, 1'b0, 9'd256);
        fetch_check("full_after_extra", 32'h0, full_word(0));
    endtask

    task automatic test_reset_midload();
        do_reset();
        send_header(16'd3, 1'b0);
        send_word(32'h1111_2222, 1'b0);
        send_word(32'h3333_4444, 1'b0);
        reset = 1'b1;
        #1;
        check_status("midload_reset", 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        fetch_check("midload_data", 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        send_header(16'd1, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        check_status("reload_done", 1'b0, 1'b0, 1'b1, 1'b0, 9'd1);
        fetch_check("reload_a0", 32'h0, 32'hDEAD_BEEF);
        fetch_check("reload_a4", 32'h4, 32'h0);
    endtask

    task automatic test_partial();
        do_reset();
        send_header(16'd2, 1'b0);
        send_word(32'h0123_4567, 1'b0);
        for (int k = 0; k < 3; k++) send_byte(8'hA0 + 8'(k), 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_status("partial_hold", 1'b1, 1'b1, 1'b0, 1'b0, 9'd2);
        fetch_check("partial_a0", 32'h0, 32'h0);
        fetch_check("partial_a4", 32'h4, 32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        address  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load18();
        test_gaps();
        test_header_err();
        test_full256();
        test_reset_midload();
        test_partial();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
